// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C[MxN] = A[MxK] * B[KxN] over single-port A/B/C memories and an external MAC.
// Build option MATMUL_TRANSPOSE_B_EN: B is stored transposed, so compute reads use b_addr = j*K+k.
module matmul_seq_ctrl #(
    parameter int unsigned M      = 3,
    parameter int unsigned K      = 3,
    parameter int unsigned N      = 3,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              a_en,
    output logic              a_we,
    output logic [ADDR_W-1:0] a_addr,
    output logic              b_en,
    output logic              b_we,
    output logic [ADDR_W-1:0] b_addr,
    output logic              c_en,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic              mac_ld,
    output logic              mac_clr
);

    localparam logic [ADDR_W-1:0] LP_ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LP_K       = ADDR_W'(K);
    localparam logic [ADDR_W-1:0] LP_N       = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] LP_M_LAST  = ADDR_W'(M - 1);
    localparam logic [ADDR_W-1:0] LP_K_LAST  = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] LP_N_LAST  = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LP_MK_LAST = ADDR_W'(M * K - 1);
    localparam logic [ADDR_W-1:0] LP_KN_LAST = ADDR_W'(K * N - 1);
    localparam logic [ADDR_W-1:0] LP_MN_LAST = ADDR_W'(M * N - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_FETCH,
        S_ACC,
        S_STORE,
        S_RD_C,
        S_OUT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ld;
    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W-1:0] r_j;
    logic [ADDR_W-1:0] r_k;
    logic [ADDR_W-1:0] r_o;

    logic [ADDR_W-1:0] w_a_rd_addr;
    logic [ADDR_W-1:0] w_b_rd_addr;
    logic [ADDR_W-1:0] w_c_wr_addr;

    // Address arithmetic is kept at ADDR_W width
    assign w_a_rd_addr = r_i * LP_K + r_k;
    assign w_c_wr_addr = r_i * LP_N + r_j;
`ifdef MATMUL_TRANSPOSE_B_EN
    assign w_b_rd_addr = r_j * LP_K + r_k;
`else
    assign w_b_rd_addr = r_k * LP_N + r_j;
`endif

    // State and loop counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ld    <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_o     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    if (in_valid) begin
                        if (r_ld == LP_MK_LAST) begin
                            r_ld    <= '0;
                            r_state <= S_LOAD_B;
                        end else begin
                            r_ld <= r_ld + LP_ONE;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (in_valid) begin
                        if (r_ld == LP_KN_LAST) begin
                            r_ld    <= '0;
                            r_state <= S_FETCH;
                        end else begin
                            r_ld <= r_ld + LP_ONE;
                        end
                    end
                end
                S_FETCH: r_state <= S_ACC;
                S_ACC: begin
                    if (r_k == LP_K_LAST) begin
                        r_k     <= '0;
                        r_state <= S_STORE;
                    end else begin
                        r_k     <= r_k + LP_ONE;
                        r_state <= S_FETCH;
                    end
                end
                S_STORE: begin
                    r_state <= S_FETCH;
                    if (r_j == LP_N_LAST) begin
                        r_j <= '0;
                        if (r_i == LP_M_LAST) begin
                            r_i     <= '0;
                            r_state <= S_RD_C;
                        end else begin
                            r_i <= r_i + LP_ONE;
                        end
                    end else begin
                        r_j <= r_j + LP_ONE;
                    end
                end
                S_RD_C: r_state <= S_OUT;
                S_OUT: begin
                    if (out_ready) begin
                        if (r_o == LP_MN_LAST) begin
                            r_o     <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_o     <= r_o + LP_ONE;
                            r_state <= S_RD_C;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output decode; everything is forced low while reset is held so an abort writes nothing
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        a_en      = 1'b0;
        a_we      = 1'b0;
        a_addr    = '0;
        b_en      = 1'b0;
        b_we      = 1'b0;
        b_addr    = '0;
        c_en      = 1'b0;
        c_we      = 1'b0;
        c_addr    = '0;
        mac_ld    = 1'b0;
        mac_clr   = 1'b0;
        if (rst) begin
            busy = (r_state != S_IDLE);
            case (r_state)
                S_IDLE:   mac_clr = start;
                S_LOAD_A: begin
                    in_ready = 1'b1;
                    a_addr   = r_ld;
                    a_en     = in_valid;
                    a_we     = in_valid;
                end
                S_LOAD_B: begin
                    in_ready = 1'b1;
                    b_addr   = r_ld;
                    b_en     = in_valid;
                    b_we     = in_valid;
                end
                S_FETCH: begin
                    a_en   = 1'b1;
                    b_en   = 1'b1;
                    a_addr = w_a_rd_addr;
                    b_addr = w_b_rd_addr;
                end
                S_ACC:    mac_ld = 1'b1;
                S_STORE: begin
                    c_en    = 1'b1;
                    c_we    = 1'b1;
                    c_addr  = w_c_wr_addr;
                    mac_clr = 1'b1;
                end
                S_RD_C: begin
                    c_en   = 1'b1;
                    c_addr = r_o;
                end
                // Address held on o while waiting so the pending element stays identifiable
                S_OUT: begin
                    out_valid = 1'b1;
                    c_addr    = r_o;
                end
                S_DONE:   done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: three sizes (3x3x3, 2x3x4, 1x1x1) with behavioural
// A/B/C memories and MAC, checked against a plain triple-loop matrix product.
module tb_matmul_seq_ctrl;

    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic [2:0]    start_v;
    logic [2:0]    in_ready_v, out_valid_v, busy_v, done_v;
    logic [2:0]    a_en_v, a_we_v, b_en_v, b_we_v, c_en_v, c_we_v, mac_ld_v, mac_clr_v;
    logic [AW-1:0] a_addr_v [3];
    logic [AW-1:0] b_addr_v [3];
    logic [AW-1:0] c_addr_v [3];

    matmul_seq_ctrl #(.M(3), .K(3), .N(3), .ADDR_W(AW)) u_dut_333 (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .busy(busy_v[0]), .done(done_v[0]),
        .a_en(a_en_v[0]), .a_we(a_we_v[0]), .a_addr(a_addr_v[0]),
        .b_en(b_en_v[0]), .b_we(b_we_v[0]), .b_addr(b_addr_v[0]),
        .c_en(c_en_v[0]), .c_we(c_we_v[0]), .c_addr(c_addr_v[0]),
        .mac_ld(mac_ld_v[0]), .mac_clr(mac_clr_v[0]));

    matmul_seq_ctrl #(.M(2), .K(3), .N(4), .ADDR_W(AW)) u_dut_234 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .busy(busy_v[1]), .done(done_v[1]),
        .a_en(a_en_v[1]), .a_we(a_we_v[1]), .a_addr(a_addr_v[1]),
        .b_en(b_en_v[1]), .b_we(b_we_v[1]), .b_addr(b_addr_v[1]),
        .c_en(c_en_v[1]), .c_we(c_we_v[1]), .c_addr(c_addr_v[1]),
        .mac_ld(mac_ld_v[1]), .mac_clr(mac_clr_v[1]));

    matmul_seq_ctrl #(.M(1), .K(1), .N(1), .ADDR_W(AW)) u_dut_111 (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .busy(busy_v[2]), .done(done_v[2]),
        .a_en(a_en_v[2]), .a_we(a_we_v[2]), .a_addr(a_addr_v[2]),
        .b_en(b_en_v[2]), .b_we(b_we_v[2]), .b_addr(b_addr_v[2]),
        .c_en(c_en_v[2]), .c_we(c_we_v[2]), .c_addr(c_addr_v[2]),
        .mac_ld(mac_ld_v[2]), .mac_clr(mac_clr_v[2]));

    // Idle instances drive all-zero outputs, so OR-ing yields the active instance's view
    logic          w_in_ready, w_out_valid, w_busy, w_done, w_a_en, w_a_we, w_b_en, w_b_we;
    logic          w_c_en, w_c_we, w_mac_ld, w_mac_clr, w_any;
    logic [AW-1:0] w_a_addr, w_b_addr, w_c_addr;
    always_comb begin
        w_in_ready  = |in_ready_v;
        w_out_valid = |out_valid_v;
        w_busy      = |busy_v;
        w_done      = |done_v;
        w_a_en      = |a_en_v;
        w_a_we      = |a_we_v;
        w_b_en      = |b_en_v;
        w_b_we      = |b_we_v;
        w_c_en      = |c_en_v;
        w_c_we      = |c_we_v;
        w_mac_ld    = |mac_ld_v;
        w_mac_clr   = |mac_clr_v;
        w_a_addr    = a_addr_v[0] | a_addr_v[1] | a_addr_v[2];
        w_b_addr    = b_addr_v[0] | b_addr_v[1] | b_addr_v[2];
        w_c_addr    = c_addr_v[0] | c_addr_v[1] | c_addr_v[2];
        w_any       = w_in_ready | w_out_valid | w_busy | w_done | w_a_en | w_a_we | w_b_en |
                      w_b_we | w_c_en | w_c_we | w_mac_ld | w_mac_clr |
                      (|w_a_addr) | (|w_b_addr) | (|w_c_addr);
    end

    // Behavioural memories (1-cycle read latency) and MAC
    int in_data;
    int a_mem [256];
    int b_mem [256];
    int c_mem [256];
    int a_rd, b_rd, c_rd, acc;
    always @(posedge clk) begin
        if (w_a_en) begin
            if (w_a_we) a_mem[w_a_addr] <= in_data;
            else        a_rd <= a_mem[w_a_addr];
        end
        if (w_b_en) begin
            if (w_b_we) b_mem[w_b_addr] <= in_data;
            else        b_rd <= b_mem[w_b_addr];
        end
        if (w_c_en) begin
            if (w_c_we) c_mem[w_c_addr] <= acc;
            else        c_rd <= c_mem[w_c_addr];
        end
        if (w_mac_clr)     acc <= 0;
        else if (w_mac_ld) acc <= acc + a_rd * b_rd;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    int src_a  [64];
    int src_b  [64];
    int exp_c  [64];
    int stream [128];
    int s_len;

    // mode 0: A=1..MK, B=KN..1; 1: identity; 2: random; 3: all A=7, B=6
    task automatic fill(input int mode, input int m, input int k, input int n);
        for (int x = 0; x < m * k; x++)
            case (mode)
                0:       src_a[x] = x + 1;
                1:       src_a[x] = ((x / k) == (x % k)) ? 1 : 0;
                2:       src_a[x] = int'($urandom_range(0, 15));
                default: src_a[x] = 7;
            endcase
        for (int x = 0; x < k * n; x++)
            case (mode)
                0:       src_b[x] = k * n - x;
                1:       src_b[x] = ((x / n) == (x % n)) ? 1 : 0;
                2:       src_b[x] = int'($urandom_range(0, 15));
                default: src_b[x] = 6;
            endcase
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++) begin
                exp_c[i * n + j] = 0;
                for (int kk = 0; kk < k; kk++)
                    exp_c[i * n + j] += src_a[i * k + kk] * src_b[kk * n + j];
            end
        s_len = 0;
        for (int x = 0; x < m * k; x++) stream[s_len++] = src_a[x];
`ifdef MATMUL_TRANSPOSE_B_EN
        for (int j = 0; j < n; j++)
            for (int kk = 0; kk < k; kk++) stream[s_len++] = src_b[kk * n + j];
`else
        for (int x = 0; x < k * n; x++) stream[s_len++] = src_b[x];
`endif
    endtask

    // vmode: 0 in_valid=1, 1 toggling, 2 random; rmode: 0 out_ready=1, 1 random
    task automatic run_job(input int sel, input int m, input int k, input int n,
                           input int vmode, input int rmode, input int stall_idx);
        int ptr = 0, n_out = 0, n_awr = 0, n_bwr = 0, bad_wr = 0, n_comp = 0, n_done = 0;
        int last_hs = -1, done_cyc = -1, last_c = -1, max_a = 0, max_b = 0, max_c = 0;
        int stall_left = 5;
        bit hs, got_done = 0, stall_on = 0;
        @(posedge clk); #1;
        start_v[sel] = 1'b1;
        in_valid     = 1'b0;
        in_data      = stream[0];
        out_ready    = (rmode == 0);
        for (int cyc = 0; cyc < 5000 && !got_done; cyc++) begin
            @(negedge clk);
            hs = in_valid && w_in_ready;
            if (w_a_we) begin chk("a_wr_addr", 32'(w_a_addr), n_awr); n_awr++; end
            if (w_b_we) begin chk("b_wr_addr", 32'(w_b_addr), n_bwr); n_bwr++; end
            if ((w_a_we || w_b_we) && !in_valid) bad_wr++;
            if ((w_a_en && !w_a_we) || w_mac_ld || w_c_we) n_comp++;
            if (w_a_en && int'(w_a_addr) > max_a) max_a = int'(w_a_addr);
            if (w_b_en && int'(w_b_addr) > max_b) max_b = int'(w_b_addr);
            if (w_c_en && int'(w_c_addr) > max_c) max_c = int'(w_c_addr);
            if (w_c_we) last_c = int'(w_c_addr);
            if (!stall_on && stall_idx >= 0 && w_out_valid && n_out == stall_idx) stall_on = 1;
            if (stall_on && stall_left > 0) begin
                chk("stall_valid", 32'(w_out_valid), 1);
                chk("stall_addr", 32'(w_c_addr), stall_idx);
                stall_left--;
            end else if (w_out_valid && out_ready) begin
                chk("c_out", c_rd, exp_c[n_out]);
                n_out++;
                last_hs = cyc;
            end
            if (w_done) begin n_done++; done_cyc = cyc; got_done = 1; end
            @(posedge clk); #1;
            start_v[sel] = stall_on && stall_left > 0;
            if (hs) ptr++;
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = !in_valid;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = (ptr < s_len) ? stream[ptr] : 0;
            if (stall_idx >= 0 && n_out == stall_idx && stall_left > 0) out_ready = 1'b0;
            else out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        start_v  = '0;
        in_valid = 1'b0;
        chk("done_seen", 32'(got_done), 1);
        chk("n_out", n_out, m * n);
        chk("n_writes", n_awr + n_bwr, m * k + k * n);
        chk("write_wo_valid", bad_wr, 0);
        chk("compute_cycles", n_comp, m * n * (2 * k + 1));
        chk("done_count", n_done, 1);
        chk("done_latency", done_cyc, last_hs + 1);
        chk("last_c_wr", last_c, m * n - 1);
        chk("max_a_addr", max_a, m * k - 1);
        chk("max_b_addr", max_b, k * n - 1);
        chk("max_c_addr", max_c, m * n - 1);
        @(negedge clk);
        chk("idle_busy", 32'(w_busy), 0);
        chk("idle_done", 32'(w_done), 0);
    endtask

    int dm [3] = '{3, 2, 1};
    int dk [3] = '{3, 3, 1};
    int dn [3] = '{3, 4, 1};

    initial begin
        rst       = 1'b0;
        start_v   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(w_any), 0);
        chk("reset_busy", 32'(w_busy), 0);

        // Abort in the middle of loading B
        @(posedge clk); #1;
        rst = 1'b1;
        fill(0, 3, 3, 3);
        start_v[0] = 1'b1;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("abort_in_load_b", 32'(w_b_we), 1);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_outputs", 32'(w_any), 0);
            chk("abort_busy", 32'(w_busy), 0);
        end
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_abort_busy", 32'(w_busy), 0);

        fill(1, 3, 3, 3); run_job(0, 3, 3, 3, 0, 0, -1);
        fill(0, 3, 3, 3); run_job(0, 3, 3, 3, 0, 0, -1);
        fill(0, 2, 3, 4); run_job(1, 2, 3, 4, 0, 0, -1);
        fill(2, 3, 3, 3); run_job(0, 3, 3, 3, 1, 0, -1);
        fill(2, 3, 3, 3); run_job(0, 3, 3, 3, 0, 0, 4);
        fill(3, 1, 1, 1); run_job(2, 1, 1, 1, 0, 0, -1);
        for (int t = 0; t < 6; t++) begin
            fill(2, dm[t % 3], dk[t % 3], dn[t % 3]);
            run_job(t % 3, dm[t % 3], dk[t % 3], dn[t % 3], 2, 1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
